fadd_issue: RTL and testbench

FADD_ISSUE -- requirements
Module: fadd_issue

---
 rtl/fadd_issue.sv | 129 ++++++++++++
 tb/tb_fadd_issue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_issue.sv
// fadd_issue: issue stage for a fixed-latency, non-stallable fadd pipeline.
// Requests are accepted only when the in-flight ops plus the buffered results
// fit in the result FIFO, so every result leaving the pipeline always has a
// slot. Results come out in issue order with their destination tags.
module fadd_issue #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      fadd_x1,
  output logic [31:0]      fadd_x2,
  input  logic [31:0]      fadd_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(LAT + DEPTH + 1) + 1;

  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    occupancy;
  logic [PW-1:0]    count;

  logic [31:0]      x1_q, x1_d;
  logic [31:0]      x2_q, x2_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [LAT];
  logic [TAG_W-1:0] tag_d [LAT];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [31:0]      mem_y_q   [DEPTH];
  logic [31:0]      mem_y_d   [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_d [DEPTH];

  // Occupancy bookkeeping and handshakes, all from registered state
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
    // Pointers carry one extra wrap bit, so their difference is the occupancy
    count     = wr_ptr_q - rd_ptr_q;
    occupancy = inflight + CW'(count);
    full      = (count == PW'(DEPTH));
    in_ready  = rstn && (occupancy < CW'(DEPTH));
    accept    = in_valid && in_ready;
    out_valid = (count != '0);
    pop       = out_valid && out_ready;
    push      = vld_q[LAT-1] && !full;
  end

  // Next state for operand registers, tracking pipe and FIFO pointers
  always_comb begin
    x1_d     = x1_q;
    x2_d     = x2_q;
    vld_d    = '0;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (accept) begin
      x1_d     = in_x1;
      x2_d     = in_x2;
      tag_d[0] = in_tag;
    end
    vld_d[0] = accept;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // Next state for the result storage: the exiting op lands at the tail
  always_comb begin
    mem_y_d   = mem_y_q;
    mem_tag_d = mem_tag_q;
    if (push) begin
      mem_y_d[wr_ptr_q[AW-1:0]]   = fadd_y;
      mem_tag_d[wr_ptr_q[AW-1:0]] = tag_q[LAT-1];
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x1_q     <= '0;
      x2_q     <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data-only state: tags in flight and FIFO contents, qualified by valids
  always_ff @(posedge clk) begin
    tag_q     <= tag_d;
    mem_y_q   <= mem_y_d;
    mem_tag_q <= mem_tag_d;
  end

  // Outputs: operands to the pipe and the FIFO head, zero while empty
  always_comb begin
    fadd_x1 = x1_q;
    fadd_x2 = x2_q;
    out_y   = out_valid ? mem_y_q[rd_ptr_q[AW-1:0]]   : '0;
    out_tag = out_valid ? mem_tag_q[rd_ptr_q[AW-1:0]] : '0;
  end

endmodule

// File: tb/tb_fadd_issue.sv
// Testbench for fadd_issue: table of single ops plus streaming, backpressure,
// simultaneous push/pop with pointer wrap, and asynchronous reset mid-flight.
module tb_fadd_issue;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fadd_x1;
  logic [31:0]      fadd_x2;
  logic [31:0]      fadd_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      y;
  } vec_t;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } sb_t;

  vec_t        vecs [6];
  sb_t         sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  logic [31:0] fpipe [LAT-1];

  fadd_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .fadd_x1   (fadd_x1),
    .fadd_x2   (fadd_x2),
    .fadd_y    (fadd_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Exact float encode/decode for non-negative integers below 2^24
  function automatic logic [31:0] int2f(input int unsigned n);
    int          p;
    logic [31:0] m;
    if (n == 0) return 32'd0;
    p = 0;
    for (int b = 0; b < 32; b++) if (n[b]) p = b;
    m = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned f2int(input logic [31:0] x);
    int          e;
    logic [31:0] m;
    if (x[30:23] == 8'd0) return 0;
    e = int'(x[30:23]) - 127;
    m = {8'd0, 1'b1, x[22:0]};
    return m >> (23 - e);
  endfunction

  function automatic logic [31:0] fadd_sum(input logic [31:0] a, input logic [31:0] b);
    return int2f(f2int(a) + f2int(b));
  endfunction

  // Behavioural fadd pipe: sum of the registered operands after LAT edges
  always @(posedge clk) begin
    fpipe[0] <= fadd_sum(fadd_x1, fadd_x2);
    for (int s = 1; s < LAT - 1; s++) fpipe[s] <= fpipe[s-1];
  end
  assign fadd_y = fpipe[LAT-2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected results queued on accept, compared on pop
  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (sb_q.size() == 0) begin
          check("stale_result", 32'(out_valid), 32'd0);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_y", out_y, e.y);
          check("sb_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        sb_t e;
        e.y   = fadd_sum(in_x1, in_x2);
        e.tag = in_tag;
        sb_q.push_back(e);
        acc_cnt++;
      end
    end
  end

  always @(negedge rstn) sb_q.delete();

  task automatic run_single(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1'b1; in_x1 = v.x1; in_x2 = v.x2; in_tag = v.tag;
    @(negedge clk);
    check("single_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT) begin
      @(negedge clk);
      check("single_early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_y", out_y, v.y);
    check("single_tag", 32'(out_tag), 32'(v.tag));
    @(negedge clk);
    check("single_one_cycle", 32'(out_valid), 32'd0);
  endtask

  task automatic wait_pops(input int target, input string name);
    for (int c = 0; c < 60 && pop_cnt < target; c++) @(negedge clk);
    #1;
    check(name, 32'(pop_cnt), 32'(target));
  endtask

  initial begin
    int base;
    int j;
    vecs[0] = '{32'h3F800000, 32'h40000000, 6'd5,  32'h40400000};
    vecs[1] = '{32'h40400000, 32'h40800000, 6'd17, 32'h40E00000};
    vecs[2] = '{32'h00000000, 32'h41000000, 6'd63, 32'h41000000};
    vecs[3] = '{32'h40A00000, 32'h40A00000, 6'd0,  32'h41200000};
    vecs[4] = '{32'h41200000, 32'h00000000, 6'd42, 32'h41200000};
    vecs[5] = '{32'h40C00000, 32'h40E00000, 6'd21, 32'h41500000};

    in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b1;

    // Reset state
    #1 rstn = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_fadd_x1", fadd_x1, 32'd0);
    check("rst_fadd_x2", fadd_x2, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Table of isolated single ops: latency, value, tag, one-cycle output
    for (int v = 0; v < 6; v++) run_single(vecs[v]);

    // Streaming: 8 back-to-back accepts, in_ready must never drop
    base = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_x1 = int2f(i + 1); in_x2 = int2f(2 * i); in_tag = 6'(i);
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_pops(base + 8, "stream_pops");

    // Backpressure: only DEPTH accepts while the consumer stalls
    @(posedge clk); #1;
    out_ready = 1'b0;
    j = 0;
    in_valid = 1'b1; in_x1 = int2f(20); in_x2 = int2f(0); in_tag = 6'd10;
    base = acc_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_ready) j++;
      @(posedge clk); #1;
      in_x1 = int2f(20 + j); in_x2 = int2f(j); in_tag = 6'(10 + j);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepts", 32'(acc_cnt - base), 32'd4);
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_head_y", out_y, int2f(20));
      check("bp_head_tag", 32'(out_tag), 32'd10);
      @(negedge clk);
    end
    base = pop_cnt;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_pops(base + 4, "bp_drain_pops");
    @(negedge clk);
    check("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Simultaneous push/pop at count=1 across a pointer wrap
    base = pop_cnt;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 12);
      in_x1 = int2f(i); in_x2 = int2f(100); in_tag = 6'(30 + i);
      @(negedge clk);
      check("pp_out_valid", 32'(out_valid), ((i >= LAT + 1) && (i <= LAT + 12)) ? 32'd1 : 32'd0);
      if (i < 12) check("pp_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    wait_pops(base + 12, "pp_pops");

    // Asynchronous reset with two results buffered and two in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_x1 = int2f(i + 1); in_x2 = int2f(1); in_tag = 6'(50 + i);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_out_y", out_y, 32'd0);
    check("arst_out_tag", 32'(out_tag), 32'd0);
    check("arst_fadd_x1", fadd_x1, 32'd0);
    check("arst_fadd_x2", fadd_x2, 32'd0);
    #2 rstn = 1'b1;
    #1;
    check("arst_rel_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("arst_no_stale", 32'(out_valid), 32'd0);
    end
    run_single(vecs[1]);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
